// File: rtl/aes_enc_iter_pkg.sv
// Shared types and helpers for the iterative AES-128 encryption engine.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOK = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column c of a 128-bit block; column 0 occupies the top word.
  function automatic logic [31:0] col_sel(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] w;
    case (c)
      2'd0:    w = s[127:96];
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      default: w = s[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_enc_iter_if.sv
// Request/response handshake bundle between the engine, its producer and consumer.
interface aes_enc_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_enc_iter_key_step.sv
// Combinational AES-128 key expansion step: current round key to the next one.
module aes_key_step (
  input  logic [127:0] rk,
  input  logic [31:0]  sub,      // S-box of word 3 bytes, unrotated
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] t, w0, w1, w2, w3;

  always_comb begin
    t  = {sub[23:0], sub[31:24]} ^ {rcon, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes_enc_iter_table_lookup.sv
// Registered T-table stage: S-box plus MixColumns multiples for the four bytes of one column.
module table_lookup
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] col,
  output logic [31:0] p0,
  output logic [31:0] p1,
  output logic [31:0] p2,
  output logic [31:0] p3
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // Inverse as a^254 (254 = 2+4+...+128), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] s0, s1, s2, s3;
  logic [7:0] d0, d1, d2, d3;
  logic [31:0] t0_p1, t1_p1, t2_p1, t3_p1;

  always_comb begin
    s0 = sbox(col[31:24]);
    s1 = sbox(col[23:16]);
    s2 = sbox(col[15:8]);
    s3 = sbox(col[7:0]);
    d0 = xtime(s0);
    d1 = xtime(s1);
    d2 = xtime(s2);
    d3 = xtime(s3);
  end

  // ---- stage p1: registered table outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t0_p1 <= '0;
      t1_p1 <= '0;
      t2_p1 <= '0;
      t3_p1 <= '0;
    end else begin
      t0_p1 <= {d0, s0, s0, d0 ^ s0};
      t1_p1 <= {d1 ^ s1, d1, s1, s1};
      t2_p1 <= {s2, d2 ^ s2, d2, s2};
      t3_p1 <= {s3, s3, d3 ^ s3, d3};
    end
  end

  assign p0 = t0_p1;
  assign p1 = t1_p1;
  assign p2 = t2_p1;
  assign p3 = t3_p1;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption: one round per LOOK/MIX pair, key expanded on the fly.
module aes_enc_iter
  import aes_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  aes_enc_iter_if.slave bus
);

  state_e       state_q, state_d;
  logic [3:0]   round_q;
  logic [127:0] state_r, rk_r, out_data_r;
  logic [7:0]   rcon_r;
  logic [31:0]  p0 [4];
  logic [31:0]  p1 [4];
  logic [31:0]  p2 [4];
  logic [31:0]  p3 [4];
  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  sub;
  logic [127:0] rk_next, full_st, last_st;
  logic         accept, last_round;
  logic         unused_k;

  for (genvar i = 0; i < 4; i++) begin : g_col
    table_lookup u_tl (
      .clk   (clk),
      .rst_n (rst_n),
      .col   (col_sel(state_r, 2'(i))),
      .p0    (p0[i]),
      .p1    (p1[i]),
      .p2    (p2[i]),
      .p3    (p3[i])
    );
  end

  table_lookup u_tl_key (
    .clk   (clk),
    .rst_n (rst_n),
    .col   (col_sel(rk_r, 2'd3)),
    .p0    (k0),
    .p1    (k1),
    .p2    (k2),
    .p3    (k3)
  );

  // Only the plain S-box byte of each key-lane table output is needed.
  assign sub      = {k0[23:16], k1[7:0], k2[7:0], k3[31:24]};
  assign unused_k = ^{k0[31:24], k0[15:0], k1[31:8], k2[31:8], k3[23:0]};

  aes_key_step u_key_step (
    .rk      (rk_r),
    .sub     (sub),
    .rcon    (rcon_r),
    .rk_next (rk_next)
  );

  // ShiftRows is folded into which column each row's table output is taken from.
  for (genvar j = 0; j < 4; j++) begin : g_mix
    assign full_st[127-32*j -: 32] = p0[j] ^ p1[(j+1)%4] ^ p2[(j+2)%4] ^ p3[(j+3)%4] ^
                                     rk_next[127-32*j -: 32];
    assign last_st[127-32*j -: 32] = {p0[j][23:16], p1[(j+1)%4][7:0],
                                      p2[(j+2)%4][7:0], p3[(j+3)%4][31:24]} ^
                                     rk_next[127-32*j -: 32];
  end

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign last_round = (round_q == NUM_ROUNDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = LOOK;
      LOOK:    state_d = MIX;
      MIX:     state_d = last_round ? DONE : LOOK;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---- round datapath: load on accept, advance one round per MIX ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= '0;
      rk_r       <= '0;
      rcon_r     <= '0;
      round_q    <= '0;
      out_data_r <= '0;
    end else if (accept) begin
      state_r <= bus.in_data ^ bus.in_key;
      rk_r    <= bus.in_key;
      rcon_r  <= RCON_INIT;
      round_q <= 4'd1;
    end else if (state_q == MIX) begin
      state_r <= last_round ? last_st : full_st;
      rk_r    <= rk_next;
      rcon_r  <= xtime(rcon_r);
      // Round count saturates at the final round so it never leaves 1..10.
      if (last_round) out_data_r <= last_st;
      else            round_q    <= round_q + 4'd1;
    end
  end

  assign bus.out_data = out_data_r;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors, backpressure, back-to-back, mid-operation reset.
module tb_aes_enc_iter;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_q[$];
  logic [127:0] out_q[$];

  aes_enc_iter_if bus ();

  aes_enc_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Records accept cycles and every completed output handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    if (rst_n && bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one vector, check latency and result, then complete the handshake.
  task automatic run_vec(input vec_t v);
    int lat;
    chk({v.name, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.in_key   = v.key;
    bus.in_data  = v.pt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({v.name, "_busy"}, 128'(bus.busy), 128'(1));
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      timeout({v.name, "_out_valid"});
    end else begin
      chk({v.name, "_latency"}, 128'(lat), 128'(20));
      chk({v.name, "_ct"}, bus.out_data, v.ct);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({v.name, "_ready_after"}, 128'(bus.in_ready), 128'(1));
    end
  endtask

  vec_t vecs[3];

  initial begin
    int n0, o0, k;
    logic [127:0] held;

    vecs[0] = '{"c1",   128'h000102030405060708090a0b0c0d0e0f,
                        128'h00112233445566778899aabbccddeeff,
                        128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{"appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                        128'h3243f6a8885a308d313198a2e0370734,
                        128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{"zero", 128'h0, 128'h0,
                        128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_key    = '0;
    bus.in_data   = '0;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Round-1 key appears in rk_r after the first MIX edge.
    bus.in_key   = vecs[1].key;
    bus.in_data  = vecs[1].pt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("appb_rk1", dut.rk_r, 128'ha0fafe1788542cb123a339392a6c7605);
    k = 0;
    while (!bus.out_valid && k < 100) begin tick(); k++; end
    chk("appb_ct2", bus.out_data, vecs[1].ct);

    // Backpressure: result held, new request ignored while DONE.
    held = bus.out_data;
    bus.in_key   = vecs[2].key;
    bus.in_data  = vecs[2].pt;
    bus.in_valid = 1'b1;
    n0 = acc_q.size();
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("bp_stable", bus.out_data, held);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid = 1'b0;
    chk("bp_no_accept", 128'(acc_q.size() - n0), 128'(0));
    o0 = out_q.size();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_handshakes", 128'(out_q.size() - o0), 128'(1));
    chk("bp_out_valid_low", 128'(bus.out_valid), 128'(0));
    chk("bp_in_ready_back", 128'(bus.in_ready), 128'(1));
    tick();
    chk("bp_idle_busy", 128'(bus.busy), 128'(0));

    // Back-to-back with in_valid and out_ready held high.
    n0 = acc_q.size();
    o0 = out_q.size();
    bus.in_key    = vecs[0].key;
    bus.in_data   = vecs[0].pt;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    k = 0;
    while (acc_q.size() <= n0 && k < 50) begin tick(); k++; end
    bus.in_key  = vecs[2].key;
    bus.in_data = vecs[2].pt;
    k = 0;
    while (acc_q.size() <= n0 + 1 && k < 50) begin tick(); k++; end
    bus.in_valid = 1'b0;
    k = 0;
    while (out_q.size() < o0 + 2 && k < 100) begin tick(); k++; end
    bus.out_ready = 1'b0;
    if (out_q.size() < o0 + 2 || acc_q.size() < n0 + 2) begin
      timeout("b2b");
    end else begin
      chk("b2b_ct0", out_q[o0], vecs[0].ct);
      chk("b2b_ct1", out_q[o0+1], vecs[2].ct);
      chk("b2b_spacing", 128'(acc_q[n0+1] - acc_q[n0]), 128'(22));
    end
    tick();

    // Reset during round 5 aborts the operation.
    o0 = out_q.size();
    bus.in_key   = vecs[1].key;
    bus.in_data  = vecs[1].pt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_out_data", bus.out_data, 128'h0);
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
    chk("abort_busy", 128'(bus.busy), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);
    repeat (30) tick();
    chk("abort_one_output", 128'(out_q.size() - o0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_iter.md
# aes_enc_iter

Iterative AES-128 encryption engine built around the existing registered T-table stage `table_lookup`: four instances process the four state columns and a fifth performs the key-schedule SubWord. The engine owns everything around those lookups:
- the load handshake and initial AddRoundKey
- the round counter and on-the-fly key expansion
- the ShiftRows/MixColumns XOR combine
- the final-round S-box extraction and the output handshake

It sits between the block-level valid/ready request interface and the ciphertext consumer.

## Interface
- (no parameters; AES-128 only, 10 rounds fixed)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  engine can accept; high only in IDLE
- in_data  in  128  plaintext, byte 0 = [127:120], column c = [127-32c -: 32]
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available, held until taken
- out_ready  in  1  consumer accepts
- out_data  out  128  ciphertext, same byte order
- busy  out  1  high in LOOK/MIX/DONE

## Operation
- States: IDLE, LOOK, MIX, DONE. Reset: state IDLE, round=0, all datapath registers 0. Output reset values: out_data=0, out_valid=0, busy=0, in_ready=1.
- IDLE: in_ready=1. On in_valid:
  - state_r <= in_data ^ in_key; rk_r <= in_key; rcon_r <= 8'h01; round <= 1; go to LOOK.
- LOOK: `table_lookup` instance i is fed state_r column i; instance K is fed rk_r word 3. The outputs are registered in the instances, so nothing combines this cycle. Go to MIX.
- MIX: let P0..P3[i] be the outputs of instance i. Per `table_lookup`:
  - P0 = {2S,S,S,3S} of byte 0; P1 = {3S,2S,S,S} of byte 1; P2 = {S,3S,2S,S} of byte 2; P3 = {S,S,3S,2S} of byte 3.
  - Next round key (via `aes_key_step`): t = {S(a1),S(a2),S(a3),S(a0)} ^ {rcon_r,24'h0}, with S(ak) taken from instance K outputs. w0'=w0^t; wk'=wk^w(k-1)' for k=1..3.
  - Full round (round 1..9): new column j = P0[j] ^ P1[j+1] ^ P2[j+2] ^ P3[j+3] ^ w'j, with column indices mod 4.
  - Final round (round 10): new column j = {P0[j][23:16], P1[j+1][7:0], P2[j+2][7:0], P3[j+3][31:24]} ^ w'j.
  - Register updates: state_r, rk_r <= w'; rcon_r <= xtime(rcon_r), i.e. ({rcon[6:0],0} ^ (rcon[7]?8'h1b:0)); round <= round+1.
  - Transition: if round==10, out_data <= new state and go to DONE; else go to LOOK.
- DONE: out_valid=1. out_data is stable until out_valid && out_ready, then go to IDLE with out_valid=0 in the same edge.
- in_valid outside IDLE is ignored; no input is captured. in_key/in_data are sampled only on the accepting edge.
- rst_n assertion mid-operation aborts immediately: the engine returns to IDLE, out_valid=0 and out_data=0. The ciphertext of an aborted operation is never emitted.
- round counter is 4 bits. The rcon sequence is 01,02,04,08,10,20,40,80,1b,36. Values outside 1..10 are never reached.

## Timing
- Accept edge = E0. Rounds occupy E1..E20 at two edges per round: LOOK then MIX.
- out_valid rises after E20 and is visible in cycle 21. Latency from acceptance to out_valid is 20 clocks.
- With out_ready held high, the minimum issue interval is 22 clocks: accept, 20 round edges, one DONE edge. in_ready returns the cycle after the DONE handshake.
- out_valid/out_data do not depend combinationally on out_ready. in_ready depends only on state.

## Structure
- Package `aes_pkg`: state enum (IDLE/LOOK/MIX/DONE), NUM_ROUNDS=10, RCON_INIT=8'h01, xtime function, column-select helper.
- Sub-module `aes_key_step`: combinational next-round-key from rk_r, the instance-K S bytes and rcon_r. It is independently testable.
- Five `table_lookup` instances are reused unchanged. No new S-box storage.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid first seen 20 clocks after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32. Also check the round-1 key a0fafe1788542cb123a339392a6c7605 at the first MIX edge.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid -> out_data stable, in_ready=0, a second in_valid ignored. On release, one handshake occurs and in_ready=1 the next cycle.
- Back-to-back: two vectors with out_ready=1 and in_valid held -> both correct, 22-clock spacing between accepts.
- Reset mid-operation: drop rst_n during round 5 -> immediately out_valid=0, out_data=0, in_ready=1. A following C.1 vector still produces 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key/pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
